// File: rtl/fifo_pkg.sv
// Shared definitions for the team's FIFO family: read-mode selectors and the
// helper that sizes the level/pointer type (ASIZE+1 bits, MSB is the wrap bit).
package fifo_pkg;

  localparam string FT_TRUE  = "TRUE";
  localparam string FT_FALSE = "FALSE";

  function automatic int unsigned level_bits(input int unsigned asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DSIZE storage with synchronous write and asynchronous read; also
// used by the dual-clock FIFO, hence the write-side clock name.
module fifo_ram #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wclken,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge wclk) begin
    if (wclken) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// fill level, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE       = 32,
  parameter int unsigned ASIZE       = 4,
  parameter string       FALLTHROUGH = "TRUE"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  input  logic [ASIZE:0]   afull_th,
  input  logic [ASIZE:0]   aempty_th,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam bit          FWFT  = (FALLTHROUGH == FT_TRUE);

  typedef logic [level_bits(ASIZE)-1:0] level_t;

  level_t           wptr, rptr;
  level_t           wptr_nxt, rptr_nxt, level_nxt;
  logic             wr_ok, rd_ok;
  logic [DSIZE-1:0] ram_rdata;

  // A write while full is refused even when a read frees a slot this cycle.
  assign wr_ok = winc && !wfull;
  assign rd_ok = rinc && !rempty;

  always_comb begin
    wptr_nxt  = wptr + level_t'(wr_ok);
    rptr_nxt  = rptr + level_t'(rd_ok);
    level_nxt = wptr_nxt - rptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      wfull     <= 1'b0;
      rempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      level  <= level_nxt;
      wfull  <= (level_nxt == level_t'(DEPTH));
      rempty <= (level_nxt == '0);
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

  assign awfull  = (level >= afull_th);
  assign arempty = (level <= aempty_th);

  fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_ram (
    .wclk   (clk),
    .wclken (wr_ok && !flush),
    .waddr  (wptr[ASIZE-1:0]),
    .wdata  (wdata),
    .raddr  (rptr[ASIZE-1:0]),
    .rdata  (ram_rdata)
  );

  generate
    if (FWFT) begin : g_fwft
      // Forced to zero while empty so the post-reset value is deterministic.
      assign rdata = rempty ? '0 : ram_rdata;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n)              rdata <= '0;
        else if (!flush && rd_ok) rdata <= ram_rdata;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench: fall-through and registered-read instances driven in
// parallel and compared against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, winc = 1'b0, rinc = 1'b0;
  logic [31:0] wdata = '0;
  logic [4:0]  afull_th = 5'd15, aempty_th = 5'd1;

  logic        f_wfull, f_awfull, f_rempty, f_arempty, f_overflow, f_underflow;
  logic [31:0] f_rdata;
  logic [4:0]  f_level;
  logic        r_wfull, r_awfull, r_rempty, r_arempty, r_overflow, r_underflow;
  logic [31:0] r_rdata;
  logic [4:0]  r_level;

  int n_tests = 0, n_fail = 0;

  logic [31:0] mq[$];
  bit          m_ovf = 0, m_udf = 0;
  logic [31:0] m_rreg = '0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DSIZE(32), .ASIZE(4), .FALLTHROUGH("TRUE")) dut_ft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(f_wfull), .awfull(f_awfull), .rinc(rinc), .rdata(f_rdata),
    .rempty(f_rempty), .arempty(f_arempty), .afull_th(afull_th),
    .aempty_th(aempty_th), .level(f_level), .overflow(f_overflow),
    .underflow(f_underflow)
  );

  sync_fifo_prog #(.DSIZE(32), .ASIZE(4), .FALLTHROUGH("FALSE")) dut_rg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(r_wfull), .awfull(r_awfull), .rinc(rinc), .rdata(r_rdata),
    .rempty(r_rempty), .arempty(r_arempty), .afull_th(afull_th),
    .aempty_th(aempty_th), .level(r_level), .overflow(r_overflow),
    .underflow(r_underflow)
  );

  // Apply one cycle of stimulus, advance the model at the edge, return at edge+1.
  task automatic drive(input bit w, input logic [31:0] d, input bit r, input bit f);
    bit was_full, was_empty;
    winc = w; wdata = d; rinc = r; flush = f;
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (!rst_n) begin
      mq.delete(); m_ovf = 0; m_udf = 0; m_rreg = '0;
    end else if (f) begin
      mq.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      if (w && was_full)  m_ovf = 1;
      if (r && was_empty) m_udf = 1;
      if (r && !was_empty) m_rreg = mq.pop_front();
      if (w && !was_full)  mq.push_back(d);
    end
    #1;
    winc = 0; rinc = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1, 32'h1234, 1, 0);
    drive(0, '0, 0, 0);
    rst_n = 1; afull_th = 5'd15; aempty_th = 5'd1;
    #1;
    n_tests++;
    if ({f_rempty, f_wfull, f_overflow, f_underflow, f_awfull, f_arempty} !== 6'b100001) begin
      n_fail++; $display("FAIL reset_flags_ft got %b want 100001",
        {f_rempty, f_wfull, f_overflow, f_underflow, f_awfull, f_arempty});
    end
    n_tests++;
    if ({r_rempty, r_wfull, r_overflow, r_underflow, r_awfull, r_arempty} !== 6'b100001) begin
      n_fail++; $display("FAIL reset_flags_rg got %b want 100001",
        {r_rempty, r_wfull, r_overflow, r_underflow, r_awfull, r_arempty});
    end
    n_tests++;
    if (f_level !== 5'd0 || r_level !== 5'd0) begin
      n_fail++; $display("FAIL reset_level got %0d/%0d want 0", f_level, r_level);
    end
    n_tests++;
    if (f_rdata !== 32'h0 || r_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h/%h want 0", f_rdata, r_rdata);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'(i), 0, 0);
      n_tests++;
      if (f_level !== 5'(i + 1) || r_level !== 5'(i + 1)) begin
        n_fail++; $display("FAIL fill_level got %0d/%0d want %0d", f_level, r_level, i + 1);
      end
    end
    n_tests++;
    if (f_wfull !== 1'b1 || r_wfull !== 1'b1 || f_rempty !== 1'b0) begin
      n_fail++; $display("FAIL fill_full got wfull=%b/%b rempty=%b want 1/1/0",
        f_wfull, r_wfull, f_rempty);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (f_rdata !== 32'(i)) begin
        n_fail++; $display("FAIL drain_ft_data got %0d want %0d", f_rdata, i);
      end
      drive(0, '0, 1, 0);
      n_tests++;
      if (r_rdata !== 32'(i)) begin
        n_fail++; $display("FAIL drain_rg_data got %0d want %0d", r_rdata, i);
      end
    end
    n_tests++;
    if (f_rempty !== 1'b1 || r_rempty !== 1'b1 || f_level !== 5'd0) begin
      n_fail++; $display("FAIL drain_empty got rempty=%b/%b level=%0d want 1/1/0",
        f_rempty, r_rempty, f_level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) drive(1, 32'h1000 + 32'(i), 0, 0);
    drive(1, 32'hDEAD, 0, 0);
    n_tests++;
    if (f_overflow !== 1'b1 || r_overflow !== 1'b1 || f_level !== 5'd16) begin
      n_fail++; $display("FAIL overflow_set got ovf=%b/%b level=%0d want 1/1/16",
        f_overflow, r_overflow, f_level);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (f_rdata !== 32'h1000 + 32'(i)) begin
        n_fail++; $display("FAIL overflow_data got %h want %h", f_rdata, 32'h1000 + 32'(i));
      end
      drive(0, '0, 1, 0);
    end
    n_tests++;
    if (r_rdata !== 32'h100F || f_overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_tail got rdata=%h ovf=%b want 100f/1", r_rdata, f_overflow);
    end
  endtask

  task automatic test_thresholds();
    drive(0, '0, 0, 1);
    afull_th = 5'd12; aempty_th = 5'd3;
    #1;
    for (int i = 1; i <= 12; i++) begin
      drive(1, $urandom, 0, 0);
      n_tests++;
      if (f_arempty !== (i <= 3) || f_awfull !== (i >= 12) || r_awfull !== (i >= 12)) begin
        n_fail++; $display("FAIL thresh_level%0d got ae=%b af=%b/%b want ae=%b af=%b",
          i, f_arempty, f_awfull, r_awfull, (i <= 3), (i >= 12));
      end
    end
    afull_th = 5'd13; #1;
    n_tests++;
    if (f_awfull !== 1'b0) begin
      n_fail++; $display("FAIL thresh_raise got awfull=%b want 0", f_awfull);
    end
    afull_th = 5'd0; aempty_th = 5'd16; #1;
    n_tests++;
    if (f_awfull !== 1'b1 || f_arempty !== 1'b1) begin
      n_fail++; $display("FAIL thresh_edge got af=%b ae=%b want 1/1", f_awfull, f_arempty);
    end
    afull_th = 5'd15; aempty_th = 5'd1; #1;
  endtask

  task automatic test_back_to_back();
    int unsigned rd_cnt = 0, wr_cnt = 0;
    drive(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) begin drive(1, 32'(wr_cnt), 0, 0); wr_cnt++; end
    for (int c = 0; c < 40; c++) begin
      n_tests++;
      if (f_rdata !== 32'(rd_cnt) || f_level !== 5'd8) begin
        n_fail++; $display("FAIL b2b_ft cycle %0d got data=%0d level=%0d want %0d/8",
          c, f_rdata, f_level, rd_cnt);
      end
      drive(1, 32'(wr_cnt), 1, 0); wr_cnt++;
      n_tests++;
      if (r_rdata !== 32'(rd_cnt) || r_level !== 5'd8) begin
        n_fail++; $display("FAIL b2b_rg cycle %0d got data=%0d level=%0d want %0d/8",
          c, r_rdata, r_level, rd_cnt);
      end
      rd_cnt++;
    end
  endtask

  task automatic test_flush();
    drive(0, '0, 0, 1);
    drive(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 32'h2000 + 32'(i), 0, 0);
    n_tests++;
    if (f_underflow !== 1'b1 || r_underflow !== 1'b1 || f_level !== 5'd5) begin
      n_fail++; $display("FAIL flush_pre got udf=%b/%b level=%0d want 1/1/5",
        f_underflow, r_underflow, f_level);
    end
    drive(1, 32'hBAD00001, 0, 1);
    n_tests++;
    if (f_level !== 5'd0 || f_rempty !== 1'b1 || f_underflow !== 1'b0 || r_underflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear got level=%0d rempty=%b udf=%b/%b want 0/1/0/0",
        f_level, f_rempty, f_underflow, r_underflow);
    end
    n_tests++;
    if (r_rdata !== m_rreg) begin
      n_fail++; $display("FAIL flush_rdata_hold got %h want %h", r_rdata, m_rreg);
    end
    drive(1, 32'h5A5A, 0, 0);
    n_tests++;
    if (f_rdata !== 32'h5A5A || f_level !== 5'd1) begin
      n_fail++; $display("FAIL flush_discard got data=%h level=%0d want 5a5a/1", f_rdata, f_level);
    end
    drive(0, '0, 1, 0);
    n_tests++;
    if (r_rdata !== 32'h5A5A) begin
      n_fail++; $display("FAIL flush_discard_rg got %h want 5a5a", r_rdata);
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_s;
    int lvl, wp;
    drive(0, '0, 0, 1);
    for (int c = 0; c < 600; c++) begin
      if (c % 25 == 0) begin
        afull_th  = 5'($urandom_range(0, 17));
        aempty_th = 5'($urandom_range(0, 17));
      end
      wp = ((c / 100) % 2 == 0) ? 70 : 30;
      if (mq.size() != 0) begin
        n_tests++;
        if (f_rdata !== mq[0]) begin
          n_fail++; $display("FAIL rand_ft_data cycle %0d got %h want %h", c, f_rdata, mq[0]);
        end
      end
      drive($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < 100 - wp,
            $urandom_range(0, 99) == 0);
      #1;
      lvl   = mq.size();
      exp_s = {5'(lvl), lvl == DEPTH, lvl == 0, lvl >= int'(afull_th),
               lvl <= int'(aempty_th), m_ovf, m_udf};
      n_tests++;
      if ({f_level, f_wfull, f_rempty, f_awfull, f_arempty, f_overflow, f_underflow} !== exp_s) begin
        n_fail++; $display("FAIL rand_ft_status cycle %0d got %b want %b", c,
          {f_level, f_wfull, f_rempty, f_awfull, f_arempty, f_overflow, f_underflow}, exp_s);
      end
      n_tests++;
      if ({r_level, r_wfull, r_rempty, r_awfull, r_arempty, r_overflow, r_underflow} !== exp_s ||
          r_rdata !== m_rreg) begin
        n_fail++; $display("FAIL rand_rg_status cycle %0d got %b/%h want %b/%h", c,
          {r_level, r_wfull, r_rempty, r_awfull, r_arempty, r_overflow, r_underflow},
          r_rdata, exp_s, m_rreg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_thresholds();
    test_back_to_back();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
